// File: rtl/arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// arb_pkg: constants, output entry type and helpers shared with the arbiter. Rev 1.0
// ---------------------------------------------------------------------------
package arb_pkg;

  localparam int NUM_PORTS_DEF = 4;
  localparam int DATA_W_DEF    = 32;
  localparam int PORT_W_DEF    = $clog2(NUM_PORTS_DEF);
  localparam int OUT_DEPTH     = 3;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [PORT_W_DEF-1:0] port;
    logic                  prio;
  } out_entry_t;

  // True for an all-zero or one-hot vector (up to 32 bits).
  function automatic logic onehot0(input logic [31:0] v);
    return (v & (v - 32'd1)) == 32'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_port_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// arb_port_fifo: per-port sync FIFO exposing head and head+1 for lookahead. Rev 1.0
// ---------------------------------------------------------------------------
module arb_port_fifo import arb_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [W-1:0]             head_next,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage carries no reset: only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign rd_ptr_next = rd_ptr + 1'b1;
  assign head        = mem[rd_ptr];
  assign head_next   = mem[rd_ptr_next];

endmodule
`default_nettype wire

// File: rtl/arb_req_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// arb_req_queue: per-port request staging and grant-driven output FIFO. Rev 1.0
// ---------------------------------------------------------------------------
module arb_req_queue import arb_pkg::*; #(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int DEPTH     = 4,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          in_valid,
  output logic [NUM_PORTS-1:0]          in_ready,
  input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
  input  logic [NUM_PORTS-1:0]          in_prio,
  output logic [NUM_PORTS-1:0]          high_priority_req,
  output logic [NUM_PORTS-1:0]          low_priority_req,
  input  logic [NUM_PORTS-1:0]          grant,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic [$clog2(NUM_PORTS)-1:0]  out_port,
  output logic                          out_prio,
  output logic                          grant_err
);

  localparam int PW  = $clog2(NUM_PORTS);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int EW  = DATA_W + 1;
  localparam int OCW = $clog2(OUT_DEPTH + 1);
  localparam int OPW = $clog2(OUT_DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [PW-1:0]     port;
    logic              prio;
  } oent_t;

  logic [EW-1:0]        head      [NUM_PORTS];
  logic [EW-1:0]        head_next [NUM_PORTS];
  logic [CW-1:0]        count     [NUM_PORTS];
  logic [NUM_PORTS-1:0] push;
  logic [NUM_PORTS-1:0] pop;

  oent_t                obuf [2**OPW];
  logic [OPW-1:0]       owr_ptr;
  logic [OPW-1:0]       ord_ptr;
  logic [OCW-1:0]       out_count;

  logic  gnt_any;
  logic  gnt_port_nonempty;
  logic  gnt_err_now;
  logic  pop_en;
  logic  out_full;
  logic  gate;
  logic  out_pop;
  oent_t gnt_entry;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [EW-1:0] eff_head;
    logic          active;

    arb_port_fifo #(
      .DEPTH (DEPTH),
      .W     (EW)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[p]),
      .push_data ({in_data[p*DATA_W +: DATA_W], in_prio[p]}),
      .pop       (pop[p]),
      .head      (head[p]),
      .head_next (head_next[p]),
      .count     (count[p])
    );

    assign in_ready[p] = (count[p] != CW'(DEPTH));
    assign push[p]     = in_valid[p] && in_ready[p];
    assign pop[p]      = grant[p] && pop_en;

    // A granted head is already on its way out, so the request reflects the entry behind it.
    assign eff_head = grant[p] ? head_next[p] : head[p];
    assign active   = count[p] > (grant[p] ? CW'(1) : CW'(0));

    assign high_priority_req[p] = active && gate &&  eff_head[0];
    assign low_priority_req[p]  = active && gate && !eff_head[0];
  end

  always_comb begin
    gnt_port_nonempty = 1'b0;
    gnt_entry         = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant[p]) begin
        gnt_port_nonempty = (count[p] != '0);
        gnt_entry.data    = head[p][EW-1:1];
        gnt_entry.port    = PW'(p);
        gnt_entry.prio    = head[p][0];
      end
    end
  end

  assign gnt_any     = (grant != '0);
  assign out_full    = (out_count == OCW'(OUT_DEPTH));
  assign gnt_err_now = !onehot0(32'(grant)) || (gnt_any && (!gnt_port_nonempty || out_full));
  assign pop_en      = gnt_any && !gnt_err_now;

  // Holding requests once two entries wait leaves room for the one grant still in flight.
  assign gate      = (out_count <= OCW'(1));
  assign out_valid = (out_count != '0);
  assign out_pop   = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owr_ptr   <= '0;
      ord_ptr   <= '0;
      out_count <= '0;
      grant_err <= 1'b0;
    end else begin
      grant_err <= gnt_err_now;
      if (pop_en)  owr_ptr <= (owr_ptr == OPW'(OUT_DEPTH - 1)) ? '0 : owr_ptr + 1'b1;
      if (out_pop) ord_ptr <= (ord_ptr == OPW'(OUT_DEPTH - 1)) ? '0 : ord_ptr + 1'b1;
      case ({pop_en, out_pop})
        2'b10:   out_count <= out_count + 1'b1;
        2'b01:   out_count <= out_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (pop_en) obuf[owr_ptr] <= gnt_entry;
  end

  // Payload outputs read as zero while empty so nothing stale shows after reset.
  assign out_data = out_valid ? obuf[ord_ptr].data : '0;
  assign out_port = out_valid ? obuf[ord_ptr].port : '0;
  assign out_prio = out_valid ? obuf[ord_ptr].prio : 1'b0;

endmodule
`default_nettype wire

// File: doc/arb_req_queue.md
Name: arb_req_queue

Overview:
- Request staging block sitting directly upstream of the registered two-level (high/low) round-robin priority arbiter.
- Buffers per-port transactions, each tagged with a priority bit, in per-port FIFOs.
- Drives the arbiter's high_priority_req/low_priority_req vectors from the effective queue heads.
- On the arbiter's registered one-hot grant, pops the granted head into a small output FIFO with a valid/ready handshake toward the consumer.

Parameters:
- NUM_PORTS, 4, number of requesting ports; must match the arbiter.
- DEPTH, 4, entries per port FIFO; power of two, ≥2.
- DATA_W, 32, payload width.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  NUM_PORTS  per-port push request.
- in_ready  output  NUM_PORTS  per-port: queue not full.
- in_data  input  NUM_PORTS*DATA_W  payloads; port p at bits [p*DATA_W +: DATA_W].
- in_prio  input  NUM_PORTS  1 = high priority entry.
- high_priority_req  output  NUM_PORTS  to arbiter.
- low_priority_req  output  NUM_PORTS  to arbiter.
- grant  input  NUM_PORTS  registered grant from arbiter.
- out_valid  output  1  output FIFO non-empty.
- out_ready  input  1  consumer accepts.
- out_data  output  DATA_W  head payload.
- out_port  output  $clog2(NUM_PORTS)  source port of head.
- out_prio  output  1  priority tag of head.
- grant_err  output  1  one-cycle pulse on an illegal grant.

Behaviour:
- Reset (rst_n low, async): all port FIFOs and the output FIFO are emptied. All outputs are 0 except in_ready, which is all-ones. grant_err = 0. Reset mid-operation discards all contents with no drain.
- Push: port p enqueues {in_data_p, in_prio_p} on a rising edge when in_valid[p] && in_ready[p]. in_ready[p] = (count_p != DEPTH). There is no pop-bypass when full.
- Pop: when grant[p] is set and count_p ≥ 1, port p's head is dequeued at that edge and written into the output FIFO as {data, p, prio}. Push and pop on the same port in the same cycle are both performed; count is unchanged.
- Stale-grant suppression: the arbiter's grant lags its request by one cycle.
  - req_active_p = count_p > (grant[p] ? 1 : 0).
  - Effective head = entry head+1 when grant[p] is set, else head.
  - high_priority_req[p] = req_active_p && gate && eff_prio_p.
  - low_priority_req[p] = req_active_p && gate && !eff_prio_p.
  - Request outputs are combinational from registered state plus grant.
- Output back-pressure: the output FIFO has a fixed depth of 3. gate = (out_count ≤ 1). One grant may be in flight, so a push into a full output FIFO can never occur.
- Output FIFO: out_valid = (out_count != 0). The head is popped on out_valid && out_ready. Simultaneous push and pop are allowed. Output order is grant order.
- Illegal grant: grant_err pulses for one cycle and the grant is dropped with no state change in these cases:
  - grant is not zero or one-hot.
  - grant targets an empty port.
  - grant arrives while out_count == 3.
- Pointer wrap-around: pointers are modulo DEPTH. count is $clog2(DEPTH)+1 bits wide.
- Latency:
  - Push to request visible: 1 cycle.
  - Request to grant (arbiter): 1 cycle.
  - Grant to out_valid: 1 cycle.
  - Empty-system push to out_valid: 3 cycles.

Decomposition:
- Shared package (arb_pkg), also used by the arbiter:
  - NUM_PORTS_DEF, DATA_W_DEF.
  - OUT_DEPTH = 3.
  - Output entry struct {data, port, prio}.
  - Helper function onehot0().
- Sub-module arb_port_fifo, instantiated NUM_PORTS times:
  - Sync FIFO with push/pop and count.
  - Exposes head and head+1 entries for the effective-head lookahead.

Test Plan:
- Reset mid-run: rst_n low with 3 entries queued → in_ready=4'hF, all reqs 0, out_valid=0 within the same cycle. No stale output after release.
- Single entry: port 2 pushes data 0xA5 with prio=1; arbiter model grants → high_priority_req=4'b0100 for exactly one cycle (stale request masked while grant[2]=1), out_valid at cycle 3 with out_data=0xA5, out_port=2, out_prio=1.
- Mixed priority lookahead: port 0 queues low then high; during the grant cycle of the first entry → low_priority_req[0]=0 and high_priority_req[0]=1. Outputs pop in order low, high.
- Full/back-pressure: fill port 1 with 4 entries → in_ready[1]=0. Hold out_ready=0 → out_count saturates at 3, reqs drop to 0 once out_count=2, no entry lost. Releasing out_ready drains all entries in order.
- Illegal grants: inject grant=4'b0011, then grant=4'b1000 with port 3 empty → grant_err pulses once each, all counts unchanged.
- Throughput: all ports continuously push with out_ready=1 → one output per cycle sustained, no grant_err, per-port order preserved.
